pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised successor to the 8-bit program counter and subroutine counter: one program counter plus a hardware return-address stack of configurable width and depth.
- Sits on the shared address bus of the SAP-2 mini datapath, feeding the MAR.
- Adds CALL/RET in one block, with full/empty status and sticky overflow/underflow error flags for the control unit.

Parameters:
- AW, 8, address width in bits (PC, bus and stack entry width); legal range 4..16.
- DEPTH, 4, number of return-address entries; must be a power of two, 2..16.
- SPW, clog2(DEPTH+1), width of the stack-occupancy output; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- bus  inout  AW  shared address bus; read on load/call, driven when enabled.
- lp  in  1  load PC from bus.
- cp  in  1  increment PC.
- call  in  1  push current PC, then load PC from bus.
- ret  in  1  pop top of stack into PC.
- ep  in  1  drive PC onto bus.
- err_clr  in  1  synchronous clear of ovf/unf.
- pc_out  out  AW  current PC, always valid (to MAR).
- sp  out  SPW  number of occupied stack entries, 0..DEPTH.
- full  out  1  sp == DEPTH.
- empty  out  1  sp == 0.
- ovf  out  1  sticky: a call was attempted while full.
- unf  out  1  sticky: a ret was attempted while empty.

Behaviour:
- Reset (clr high, async, any time, including mid-operation):
  - pc = 0, sp = 0, ovf = 0, unf = 0; empty = 1, full = 0.
  - Stack RAM contents are don't-care; no entry is readable until pushed.
- Operation per rising clk, priority call > ret > lp > cp; lower-priority requests in the same cycle are ignored.
- call:
  - If not full: stack[sp] <= pc; sp <= sp+1; pc <= bus.
  - If full: pc and sp unchanged, nothing written, ovf <= 1.
- ret:
  - If not empty: pc <= stack[sp-1]; sp <= sp-1.
  - If empty: pc and sp unchanged, unf <= 1.
- lp: pc <= bus.
- cp: pc <= pc+1, modulo 2^AW. All-ones wraps to 0 with no flag.
- No request: all state holds.
- Latency: every update is visible on pc_out/sp/full/empty one cycle after the edge that samples the request; no combinational path from request inputs to pc_out.
- Bus drive:
  - bus = pc_out when ep && !lp && !call; otherwise high-Z.
  - ep together with lp or call is a read cycle; the block never drives and samples bus in the same cycle.
- Error flags:
  - err_clr clears ovf/unf on the edge.
  - If err_clr and a new error event occur in the same cycle, the flag is set (set wins).
- The stack is LIFO with no wrap. A push never overwrites a valid entry; a pop never returns a stale entry.
- full/empty are combinational decodes of sp and stay consistent with it every cycle.

Test Plan:
- Reset/count: pulse clr mid-cycle -> pc_out=0x00, sp=0, empty=1 at once (async). Then cp for 3 cycles -> pc_out=0x03. Load 0xFF via lp, one cp -> pc_out=0x00.
- Call/return nesting: pc=0x10, call with bus=0x40 -> pc=0x40, sp=1. cp to 0x42, call with bus=0x80 -> pc=0x80, sp=2. ret -> pc=0x42, sp=1. ret -> pc=0x10, sp=0, empty=1.
- Overflow: 4 calls with bus=0x20,0x30,0x40,0x50 -> sp=4, full=1. A 5th call with bus=0x99 -> pc stays 0x50, sp=4, ovf=1. Four rets then return to the original addresses in reverse order.
- Underflow and err_clr: ret when empty -> pc unchanged, unf=1; it stays 1 across later valid ops. err_clr -> unf=0. err_clr and an empty ret in the same cycle -> unf=1.
- Priority: call+ret+lp+cp asserted together with bus=0x33, pc=0x05 -> pc=0x33, sp+1, pushed entry=0x05. lp+cp together, bus=0x07 -> pc=0x07.
- Bus contention: ep=1, pc=0xA5 -> bus=0xA5. ep=1 with lp=1 and tb driving 0x11 -> no X on bus, pc=0x11 next cycle. ep=0 -> bus high-Z.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter with a hardware return-address stack.
// One PC register drives the MAR directly and can be loaded from, or
// driven onto, the shared address bus. CALL pushes the current PC and
// loads the bus value; RET pops the most recent return address back
// into the PC. Occupancy, full/empty and sticky overflow/underflow flags
// are reported to the control unit.
module pc_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           clr,
    inout  wire  [AW-1:0]  bus,
    input  logic           lp,
    input  logic           cp,
    input  logic           call,
    input  logic           ret,
    input  logic           ep,
    input  logic           err_clr,
    output logic [AW-1:0]  pc_out,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    output logic           ovf,
    output logic           unf
);

    // Index width into the stack storage; DEPTH is a power of two, so
    // sp (0..DEPTH) truncated to IW bits addresses the next free slot.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject illegal parameterisations at elaboration time.
    generate
        if (AW < 4 || AW > 16) begin : g_bad_aw
            $error("pc_stack: AW must be in 4..16");
        end
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pc_stack: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [AW-1:0]  pc_q,  pc_d;
    logic [SPW-1:0] sp_q,  sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    // Return-address storage; contents are don't-care until pushed, so
    // it carries no reset and maps onto plain registers/LUT-RAM.
    logic [AW-1:0]  stack_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic          is_full;
    logic          is_empty;
    logic          do_call;     // call request wins this cycle
    logic          do_ret;      // ret request wins this cycle
    logic          do_lp;       // lp request wins this cycle
    logic          do_cp;       // cp request wins this cycle
    logic          push_en;     // call that actually writes the stack
    logic          pop_en;      // ret that actually reads the stack
    logic          ovf_event;   // call attempted while full
    logic          unf_event;   // ret attempted while empty
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] top_entry;
    logic          bus_drive;

    assign is_full  = (sp_q == SPW'(DEPTH));
    assign is_empty = (sp_q == '0);

    // Fixed priority call > ret > lp > cp; losers are simply dropped.
    always_comb begin
        do_call = call;
        do_ret  = !call && ret;
        do_lp   = !call && !ret && lp;
        do_cp   = !call && !ret && !lp && cp;
    end

    assign push_en   = do_call && !is_full;
    assign pop_en    = do_ret  && !is_empty;
    assign ovf_event = do_call && is_full;
    assign unf_event = do_ret  && is_empty;

    // Slot sp is the next free entry, slot sp-1 the top of stack. Both
    // indices only matter when the matching enable is true, so the
    // truncation at sp == DEPTH (write) or sp == 0 (read) is harmless.
    assign wr_idx = sp_q[IW-1:0];
    assign rd_idx = IW'(sp_q - SPW'(1));

    // Read mux for the top-of-stack entry, consumed only by a pop.
    always_comb begin
        top_entry = stack_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IW'(i)) begin
                top_entry = stack_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Compute next PC and occupancy from the winning request.
    always_comb begin
        pc_d = pc_q;
        sp_d = sp_q;
        if (push_en) begin
            pc_d = bus;
            sp_d = sp_q + SPW'(1);
        end else if (pop_en) begin
            pc_d = top_entry;
            sp_d = sp_q - SPW'(1);
        end else if (do_lp) begin
            pc_d = bus;
        end else if (do_cp) begin
            pc_d = pc_q + AW'(1);
        end
    end

    // Sticky error flags: err_clr clears, a same-cycle event still sets.
    always_comb begin
        ovf_d = (ovf_q && !err_clr) || ovf_event;
        unf_d = (unf_q && !err_clr) || unf_event;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // PC, occupancy and error flags with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // One write port per entry; only the addressed slot captures the PC.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the return address into this slot on a valid push.
            always_ff @(posedge clk) begin
                if (push_en && wr_idx == IW'(gi)) begin
                    stack_q[gi] <= pc_q;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Never drive the bus in a cycle where it is being sampled.
    assign bus_drive = ep && !lp && !call;
    assign bus       = bus_drive ? pc_q : {AW{1'bz}};

    assign pc_out = pc_q;
    assign sp     = sp_q;
    assign full   = is_full;
    assign empty  = is_empty;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_pc_stack;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           lp = 0, cp = 0, call = 0, ret = 0, ep = 0, err_clr = 0;
    logic           tb_en = 1'b0;
    logic [AW-1:0]  tb_val = '0;
    wire  [AW-1:0]  bus;
    logic [AW-1:0]  pc_out;
    logic [SPW-1:0] sp;
    logic           full, empty, ovf, unf;

    int errors = 0;
    int checks = 0;

    assign bus = tb_en ? tb_val : {AW{1'bz}};

    pc_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .bus(bus), .lp(lp), .cp(cp), .call(call),
        .ret(ret), .ep(ep), .err_clr(err_clr), .pc_out(pc_out), .sp(sp),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_pc  = '0;
    logic [AW-1:0] m_stk [$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_pc = '0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            logic ov, un;
            ov = 1'b0;
            un = 1'b0;
            if (call) begin
                if (m_stk.size() == DEPTH) ov = 1'b1;
                else begin
                    m_stk.push_back(m_pc);
                    m_pc = tb_val;
                end
            end else if (ret) begin
                if (m_stk.size() == 0) un = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (lp) begin
                m_pc = tb_val;
            end else if (cp) begin
                m_pc = m_pc + 1'b1;
            end
            m_ovf = (m_ovf && !err_clr) || ov;
            m_unf = (m_unf && !err_clr) || un;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        chk("m_pc", int'(pc_out), int'(m_pc));
        chk("m_sp", int'(sp), m_stk.size());
        chk("m_full", int'(full), int'(m_stk.size() == DEPTH));
        chk("m_empty", int'(empty), int'(m_stk.size() == 0));
        chk("m_ovf", int'(ovf), int'(m_ovf));
        chk("m_unf", int'(unf), int'(m_unf));
        if (tb_en)
            chk("m_bus_tb", int'(bus), int'(tb_val));
        else if (ep)
            chk("m_bus_pc", int'(bus), int'(m_pc));
    end

    // Apply one cycle of requests; return 2 time units after the edge.
    task automatic op(input logic c, input logic r, input logic l, input logic i,
                      input logic e, input logic ec, input logic [AW-1:0] v);
        call = c; ret = r; lp = l; cp = i; ep = e; err_clr = ec;
        tb_val = v; tb_en = c | l;
        @(posedge clk);
        #2;
        $display("op call=%0b ret=%0b lp=%0b cp=%0b ep=%0b ec=%0b bus_in=%02h -> pc=%02h sp=%0d ovf=%0b unf=%0b",
                 c, r, l, i, e, ec, v, pc_out, sp, ovf, unf);
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    logic [AW-1:0] ret_addrs [4];

    initial begin
        // Reset held from time 0
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", int'(pc_out), 0);
        chk("rst_sp", int'(sp), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        clr = 1'b0;

        // Reset/count with a mid-cycle asynchronous clear
        op(0, 0, 1, 0, 0, 0, 8'h5C);
        op(0, 0, 0, 0, 0, 0, 8'h00);
        #1 clr = 1'b1;
        #1;
        chk("async_pc", int'(pc_out), 0);
        chk("async_sp", int'(sp), 0);
        chk("async_empty", int'(empty), 1);
        @(negedge clk);
        #1 clr = 1'b0;
        repeat (3) op(0, 0, 0, 1, 0, 0, 8'h00);
        chk("cp3", int'(pc_out), 8'h03);
        op(0, 0, 1, 0, 0, 0, 8'hFF);
        op(0, 0, 0, 1, 0, 0, 8'h00);
        chk("wrap", int'(pc_out), 8'h00);

        // Call/return nesting
        op(0, 0, 1, 0, 0, 0, 8'h10);
        op(1, 0, 0, 0, 0, 0, 8'h40);
        chk("call1_pc", int'(pc_out), 8'h40);
        chk("call1_sp", int'(sp), 1);
        op(0, 0, 0, 1, 0, 0, 8'h00);
        op(0, 0, 0, 1, 0, 0, 8'h00);
        op(1, 0, 0, 0, 0, 0, 8'h80);
        chk("call2_pc", int'(pc_out), 8'h80);
        chk("call2_sp", int'(sp), 2);
        op(0, 1, 0, 0, 0, 0, 8'h00);
        chk("ret1_pc", int'(pc_out), 8'h42);
        chk("ret1_sp", int'(sp), 1);
        op(0, 1, 0, 0, 0, 0, 8'h00);
        chk("ret2_pc", int'(pc_out), 8'h10);
        chk("ret2_empty", int'(empty), 1);

        // Overflow
        op(1, 0, 0, 0, 0, 0, 8'h20);
        op(1, 0, 0, 0, 0, 0, 8'h30);
        op(1, 0, 0, 0, 0, 0, 8'h40);
        op(1, 0, 0, 0, 0, 0, 8'h50);
        chk("ovf_sp4", int'(sp), 4);
        chk("ovf_full", int'(full), 1);
        op(1, 0, 0, 0, 0, 0, 8'h99);
        chk("ovf_pc", int'(pc_out), 8'h50);
        chk("ovf_sp", int'(sp), 4);
        chk("ovf_flag", int'(ovf), 1);
        ret_addrs[0] = 8'h40; ret_addrs[1] = 8'h30;
        ret_addrs[2] = 8'h20; ret_addrs[3] = 8'h10;
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 0, 0, 0, 0, 8'h00);
            chk("ovf_ret", int'(pc_out), int'(ret_addrs[i]));
        end
        op(0, 0, 0, 0, 0, 1, 8'h00);
        chk("ovf_clr", int'(ovf), 0);

        // Underflow and err_clr
        op(0, 1, 0, 0, 0, 0, 8'h00);
        chk("unf_pc", int'(pc_out), 8'h10);
        chk("unf_flag", int'(unf), 1);
        op(0, 0, 0, 1, 0, 0, 8'h00);
        op(1, 0, 0, 0, 0, 0, 8'h60);
        chk("unf_sticky", int'(unf), 1);
        op(0, 0, 0, 0, 0, 1, 8'h00);
        chk("unf_clr", int'(unf), 0);
        op(0, 1, 0, 0, 0, 0, 8'h00);
        op(0, 1, 0, 0, 0, 1, 8'h00);
        chk("unf_setwins", int'(unf), 1);
        op(0, 0, 0, 0, 0, 1, 8'h00);

        // Priority
        op(0, 0, 1, 0, 0, 0, 8'h05);
        op(1, 1, 1, 1, 0, 0, 8'h33);
        chk("prio_pc", int'(pc_out), 8'h33);
        chk("prio_sp", int'(sp), 1);
        op(0, 1, 0, 0, 0, 0, 8'h00);
        chk("prio_entry", int'(pc_out), 8'h05);
        op(0, 0, 1, 1, 0, 0, 8'h07);
        chk("lp_cp", int'(pc_out), 8'h07);

        // Bus drive and contention
        op(0, 0, 1, 0, 0, 0, 8'hA5);
        ep = 1'b1; #1;
        chk("bus_drive", int'(bus), 8'hA5);
        lp = 1'b1; tb_val = 8'h11; tb_en = 1'b1; #1;
        chk("bus_read", int'(bus), 8'h11);
        @(posedge clk); #2;
        chk("bus_load", int'(pc_out), 8'h11);
        ep = 1'b0; lp = 1'b0; tb_val = 8'h5A; #1;
        chk("bus_hiz", int'(bus), 8'h5A);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int k;
            logic c, r, l, i, e, ec;
            k = $urandom_range(0, 99);
            c = (k < 22);
            r = (k >= 22 && k < 44);
            l = (k >= 44 && k < 54);
            i = (k >= 54);
            if ($urandom_range(0, 9) == 0) begin c = 1'b1; r = 1'($urandom); end
            e  = 1'($urandom);
            ec = ($urandom_range(0, 19) == 0);
            call = c; ret = r; lp = l; cp = i; ep = e; err_clr = ec;
            tb_val = AW'($urandom);
            tb_en = c | l | (!e && 1'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                #1 clr = 1'b1;
                #1 clr = 1'b0;
            end
            @(posedge clk);
            #2;
            if (n % 100 == 0)
                $display("rnd %0d: pc=%02h sp=%0d ovf=%0b unf=%0b", n, pc_out, sp, ovf, unf);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
